// File: rtl/core_hazard_pkg.sv
// Shared types and constants for the Selen core hazard controller.
// Pipeline-stage indices, enable/kill masks and the interlock state encoding.
package core_hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam int REG_IF_DEC  = 0;
  localparam int REG_DEC_EXE = 1;
  localparam int REG_EXE_MEM = 2;
  localparam int REG_MEM_WB  = 3;

  // Wide masks; the top slices them down to N_STG bits (N_STG <= STG_MAX).
  localparam int STG_MAX = 16;
  localparam logic [STG_MAX-1:0] ENB_ON   = '1;
  localparam logic [STG_MAX-1:0] ENB_OFF  = '0;
  localparam logic [STG_MAX-1:0] KILL_ON  = '1;
  localparam logic [STG_MAX-1:0] KILL_OFF = '0;

  // Load-use bubble counter width, enough for LOAD_LAT up to 7.
  localparam int LD_CW = 3;

endpackage

// File: rtl/core_fwd_sel.sv
// Priority forwarding select for one EXE source operand.
// The youngest writer (lowest index) that targets rs wins; x0 never forwards.
module core_fwd_sel #(
  parameter int REG_AW = 5,
  parameter int N_FWD  = 2,
  parameter int SEL_W  = $clog2(N_FWD + 1)
) (
  input  logic [REG_AW-1:0]       rs,
  input  logic [N_FWD*REG_AW-1:0] fwd_rd,
  input  logic [N_FWD-1:0]        fwd_we,
  output logic [SEL_W-1:0]        sel
);

  logic [N_FWD-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_FWD; gi++) begin : g_hit
      assign hit[gi] = fwd_we[gi] && (fwd_rd[gi*REG_AW +: REG_AW] == rs) && (rs != '0);
    end
  endgenerate

  // Scan oldest to youngest so the youngest hit overwrites the rest.
  always_comb begin
    sel = '0;
    for (int k = N_FWD - 1; k >= 0; k--) begin
      if (hit[k]) sel = SEL_W'(k + 1);
    end
  end

endmodule

// File: rtl/core_hazard_unit.sv
// Hazard controller: operand forwarding, load-use interlock, redirect flush,
// cache-stall freezing with a pending redirect latch, and a stall-cycle counter.
module core_hazard_unit
  import core_hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int N_FWD       = 2,
  parameter int N_STG       = 4,
  parameter int FLUSH_DEPTH = 2,
  parameter int LOAD_LAT    = 1,
  parameter int CNT_W       = 32,
  parameter int SEL_W       = $clog2(N_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_AW-1:0]       dec_rs1,
  input  logic [REG_AW-1:0]       dec_rs2,
  input  logic [1:0]              dec_rs_vld,
  input  logic [REG_AW-1:0]       exe_rs1,
  input  logic [REG_AW-1:0]       exe_rs2,
  input  logic [REG_AW-1:0]       exe_rd,
  input  logic                    exe_we,
  input  logic                    exe_is_load,
  input  logic                    exe_redirect,
  input  logic [N_FWD*REG_AW-1:0] fwd_rd,
  input  logic [N_FWD-1:0]        fwd_we,
  input  logic                    imem_stall,
  input  logic                    dmem_stall,
  output logic [SEL_W-1:0]        fwd_sel_rs1,
  output logic [SEL_W-1:0]        fwd_sel_rs2,
  output logic [N_STG-1:0]        enb_bus,
  output logic [N_STG-1:0]        kill_bus,
  output logic                    pc_stop,
  output logic                    nop_gen,
  output logic                    redirect,
  output logic [CNT_W-1:0]        stall_cycles
);

  localparam logic [LD_CW-1:0] LD_INIT = LD_CW'(LOAD_LAT - 1);

  hz_state_e        state_q, state_d;
  logic [LD_CW-1:0] ld_cnt_q, ld_cnt_d;
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic [SEL_W-1:0] sel_rs1, sel_rs2;
  logic             load_use;
  logic             redir_src;

  core_fwd_sel #(.REG_AW(REG_AW), .N_FWD(N_FWD), .SEL_W(SEL_W)) u_fwd_rs1 (
    .rs(exe_rs1), .fwd_rd(fwd_rd), .fwd_we(fwd_we), .sel(sel_rs1)
  );

  core_fwd_sel #(.REG_AW(REG_AW), .N_FWD(N_FWD), .SEL_W(SEL_W)) u_fwd_rs2 (
    .rs(exe_rs2), .fwd_rd(fwd_rd), .fwd_we(fwd_we), .sel(sel_rs2)
  );

  assign load_use = exe_is_load && exe_we && (exe_rd != '0) &&
                    ((dec_rs_vld[0] && (dec_rs1 == exe_rd)) ||
                     (dec_rs_vld[1] && (dec_rs2 == exe_rd)));
  assign redir_src = exe_redirect || redir_pend_q;

  always_comb begin
    enb_bus      = ENB_ON[N_STG-1:0];
    kill_bus     = KILL_OFF[N_STG-1:0];
    pc_stop      = 1'b0;
    nop_gen      = 1'b0;
    redirect     = 1'b0;
    fwd_sel_rs1  = sel_rs1;
    fwd_sel_rs2  = sel_rs2;
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    redir_pend_d = redir_pend_q;

    if (dmem_stall) begin
      // Whole pipe frozen; a redirect seen now is parked until memory returns.
      enb_bus = ENB_OFF[N_STG-1:0];
      pc_stop = 1'b1;
      state_d = MEM_WAIT;
      if (exe_redirect) redir_pend_d = 1'b1;
    end else if (redir_src) begin
      redirect                   = 1'b1;
      kill_bus[FLUSH_DEPTH-1:0]  = '1;
      redir_pend_d               = 1'b0;
      ld_cnt_d                   = '0;
      state_d                    = RUN;
    end else if (state_q == LD_STALL) begin
      enb_bus[REG_IF_DEC] = 1'b0;
      nop_gen             = 1'b1;
      pc_stop             = 1'b1;
      ld_cnt_d            = ld_cnt_q - 1'b1;
      if (ld_cnt_q == LD_CW'(1)) state_d = RUN;
    end else if (load_use) begin
      enb_bus[REG_IF_DEC] = 1'b0;
      nop_gen             = 1'b1;
      pc_stop             = 1'b1;
      ld_cnt_d            = LD_INIT;
      state_d             = (LOAD_LAT > 1) ? LD_STALL : RUN;
    end else begin
      if (imem_stall) begin
        enb_bus[REG_IF_DEC] = 1'b0;
        nop_gen             = 1'b1;
        pc_stop             = 1'b1;
      end
      // Leaving MEM_WAIT resumes any load bubbles frozen by the cache miss.
      if (state_q == MEM_WAIT) state_d = (ld_cnt_q != '0) ? LD_STALL : RUN;
    end

    if (rst) begin
      enb_bus     = ENB_ON[N_STG-1:0];
      kill_bus    = KILL_ON[N_STG-1:0];
      pc_stop     = 1'b1;
      nop_gen     = 1'b0;
      redirect    = 1'b0;
      fwd_sel_rs1 = '0;
      fwd_sel_rs2 = '0;
    end

    stall_cycles_d = stall_cycles_q;
    if (pc_stop && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      ld_cnt_q       <= '0;
      redir_pend_q   <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      ld_cnt_q       <= ld_cnt_d;
      redir_pend_q   <= redir_pend_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_core_hazard_unit.sv
// Scoreboard bench for core_hazard_unit: directed scenarios then random traffic,
// each cycle's expected outputs come from a bubble/pending-redirect reference model.
module tb_core_hazard_unit;

  localparam int REG_AW      = 5;
  localparam int N_FWD       = 2;
  localparam int N_STG       = 4;
  localparam int FLUSH_DEPTH = 2;
  localparam int LOAD_LAT    = 2;
  localparam int CNT_W       = 4;
  localparam int SEL_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct {
    logic                    rst;
    logic [REG_AW-1:0]       dec_rs1, dec_rs2;
    logic [1:0]              dec_rs_vld;
    logic [REG_AW-1:0]       exe_rs1, exe_rs2, exe_rd;
    logic                    exe_we, exe_is_load, exe_redirect;
    logic [N_FWD*REG_AW-1:0] fwd_rd;
    logic [N_FWD-1:0]        fwd_we;
    logic                    imem, dmem;
  } stim_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel1;
    logic [SEL_W-1:0] sel2;
    logic [N_STG-1:0] enb;
    logic [N_STG-1:0] kill;
    logic             pc_stop;
    logic             nop;
    logic             redirect;
    logic [CNT_W-1:0] stall;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [REG_AW-1:0]       dec_rs1 = '0, dec_rs2 = '0;
  logic [1:0]              dec_rs_vld = '0;
  logic [REG_AW-1:0]       exe_rs1 = '0, exe_rs2 = '0, exe_rd = '0;
  logic                    exe_we = 1'b0, exe_is_load = 1'b0, exe_redirect = 1'b0;
  logic [N_FWD*REG_AW-1:0] fwd_rd = '0;
  logic [N_FWD-1:0]        fwd_we = '0;
  logic                    imem_stall = 1'b0, dmem_stall = 1'b0;
  logic [SEL_W-1:0]        fwd_sel_rs1, fwd_sel_rs2;
  logic [N_STG-1:0]        enb_bus, kill_bus;
  logic                    pc_stop, nop_gen, redirect;
  logic [CNT_W-1:0]        stall_cycles;

  always #5 clk = ~clk;

  core_hazard_unit #(
    .REG_AW(REG_AW), .N_FWD(N_FWD), .N_STG(N_STG), .FLUSH_DEPTH(FLUSH_DEPTH),
    .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs_vld(dec_rs_vld),
    .exe_rs1(exe_rs1), .exe_rs2(exe_rs2), .exe_rd(exe_rd),
    .exe_we(exe_we), .exe_is_load(exe_is_load), .exe_redirect(exe_redirect),
    .fwd_rd(fwd_rd), .fwd_we(fwd_we),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
    .enb_bus(enb_bus), .kill_bus(kill_bus),
    .pc_stop(pc_stop), .nop_gen(nop_gen), .redirect(redirect),
    .stall_cycles(stall_cycles)
  );

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state: load bubbles still owed, whether a cache miss is
  // being recovered from, a parked redirect, and the stall counter.
  int m_bubbles = 0;
  bit m_memwait = 1'b0;
  bit m_pend    = 1'b0;
  int m_cnt     = 0;

  function automatic logic [SEL_W-1:0] fwd_ref(input logic [REG_AW-1:0] rs,
                                               input logic [N_FWD*REG_AW-1:0] rd,
                                               input logic [N_FWD-1:0] we);
    if (rs == 0) return '0;
    for (int k = 0; k < N_FWD; k++)
      if (we[k] && rd[k*REG_AW +: REG_AW] == rs) return SEL_W'(k + 1);
    return '0;
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s.rst = 1'b0; s.dec_rs1 = '0; s.dec_rs2 = '0; s.dec_rs_vld = '0;
    s.exe_rs1 = '0; s.exe_rs2 = '0; s.exe_rd = '0;
    s.exe_we = 1'b0; s.exe_is_load = 1'b0; s.exe_redirect = 1'b0;
    s.fwd_rd = '0; s.fwd_we = '0; s.imem = 1'b0; s.dmem = 1'b0;
    return s;
  endfunction

  function automatic stim_t load_use_s();
    stim_t s = idle_s();
    s.exe_is_load = 1'b1; s.exe_we = 1'b1; s.exe_rd = 5'd5;
    s.dec_rs1 = 5'd5; s.dec_rs_vld = 2'b01;
    return s;
  endfunction

  task automatic model(input stim_t s, output exp_t e);
    bit lu;
    lu = s.exe_is_load && s.exe_we && s.exe_rd != 0 &&
         ((s.dec_rs_vld[0] && s.dec_rs1 == s.exe_rd) ||
          (s.dec_rs_vld[1] && s.dec_rs2 == s.exe_rd));
    e.stall    = CNT_W'(m_cnt);
    e.sel1     = s.rst ? '0 : fwd_ref(s.exe_rs1, s.fwd_rd, s.fwd_we);
    e.sel2     = s.rst ? '0 : fwd_ref(s.exe_rs2, s.fwd_rd, s.fwd_we);
    e.enb      = '1;
    e.kill     = '0;
    e.pc_stop  = 1'b0;
    e.nop      = 1'b0;
    e.redirect = 1'b0;
    if (s.rst) begin
      e.kill = '1; e.pc_stop = 1'b1;
      m_bubbles = 0; m_memwait = 1'b0; m_pend = 1'b0;
    end else if (s.dmem) begin
      e.enb = '0; e.pc_stop = 1'b1;
      m_memwait = 1'b1;
      if (s.exe_redirect) m_pend = 1'b1;
    end else if (s.exe_redirect || m_pend) begin
      e.redirect = 1'b1;
      e.kill = N_STG'((1 << FLUSH_DEPTH) - 1);
      m_pend = 1'b0; m_bubbles = 0; m_memwait = 1'b0;
    end else if (m_bubbles > 0 && !m_memwait) begin
      e.enb[0] = 1'b0; e.nop = 1'b1; e.pc_stop = 1'b1;
      m_bubbles--;
    end else if (lu) begin
      e.enb[0] = 1'b0; e.nop = 1'b1; e.pc_stop = 1'b1;
      m_bubbles = LOAD_LAT - 1; m_memwait = 1'b0;
    end else begin
      if (s.imem) begin
        e.enb[0] = 1'b0; e.nop = 1'b1; e.pc_stop = 1'b1;
      end
      m_memwait = 1'b0;
    end
    if (s.rst) m_cnt = 0;
    else if (e.pc_stop && m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; dec_rs1 = s.dec_rs1; dec_rs2 = s.dec_rs2; dec_rs_vld = s.dec_rs_vld;
    exe_rs1 = s.exe_rs1; exe_rs2 = s.exe_rs2; exe_rd = s.exe_rd;
    exe_we = s.exe_we; exe_is_load = s.exe_is_load; exe_redirect = s.exe_redirect;
    fwd_rd = s.fwd_rd; fwd_we = s.fwd_we; imem_stall = s.imem; dmem_stall = s.dmem;
    model(s, e);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per falling edge.
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{fwd_sel_rs1, fwd_sel_rs2, enb_bus, kill_bus, pc_stop, nop_gen, redirect, stall_cycles};
        n_vec++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL vec %0d: got sel=%0d/%0d enb=%b kill=%b stop=%b nop=%b redir=%b cnt=%0d, want sel=%0d/%0d enb=%b kill=%b stop=%b nop=%b redir=%b cnt=%0d",
                   n_vec, g.sel1, g.sel2, g.enb, g.kill, g.pc_stop, g.nop, g.redirect, g.stall,
                   e.sel1, e.sel2, e.enb, e.kill, e.pc_stop, e.nop, e.redirect, e.stall);
        end else begin
          $display("vec %0d ok sel=%0d/%0d enb=%b kill=%b stop=%b nop=%b redir=%b cnt=%0d",
                   n_vec, g.sel1, g.sel2, g.enb, g.kill, g.pc_stop, g.nop, g.redirect, g.stall);
        end
      end
    end
  end

  initial begin
    stim_t s;
    // Reset
    s = idle_s(); s.rst = 1'b1;
    repeat (3) apply(s);
    // Forwarding: MEM beats WB, x0 never forwards
    s = idle_s(); s.fwd_we = 2'b11; s.fwd_rd = {5'd3, 5'd3}; s.exe_rs1 = 5'd3; s.exe_rs2 = 5'd3;
    apply(s);
    s.exe_rs1 = 5'd0; s.fwd_we = 2'b10; apply(s);
    s.fwd_rd = {5'd7, 5'd9}; s.fwd_we = 2'b11; s.exe_rs1 = 5'd7; s.exe_rs2 = 5'd9; apply(s);
    // Load-use from a clean reset: two bubbles, counter ends at 2
    s = idle_s(); s.rst = 1'b1; apply(s);
    apply(load_use_s());
    repeat (3) apply(idle_s());
    // Redirect pulse in RUN
    s = idle_s(); s.exe_redirect = 1'b1; apply(s);
    repeat (2) apply(idle_s());
    // Cache miss with a redirect parked in its first cycle
    s = idle_s(); s.dmem = 1'b1; s.exe_redirect = 1'b1; apply(s);
    s.exe_redirect = 1'b0; repeat (2) apply(s);
    repeat (3) apply(idle_s());
    // Cache miss landing in LD_STALL with one bubble left
    apply(load_use_s());
    s = idle_s(); s.dmem = 1'b1; repeat (2) apply(s);
    repeat (4) apply(idle_s());
    // Reset in the middle of a load stall
    apply(load_use_s());
    s = idle_s(); s.rst = 1'b1; repeat (2) apply(s);
    repeat (2) apply(idle_s());
    // Instruction-cache stall long enough to saturate the counter
    s = idle_s(); s.imem = 1'b1; repeat (20) apply(s);
    repeat (2) apply(idle_s());
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      s = idle_s();
      s.rst          = ($urandom_range(0, 79) == 0);
      s.dec_rs1      = REG_AW'($urandom_range(0, 7));
      s.dec_rs2      = REG_AW'($urandom_range(0, 7));
      s.dec_rs_vld   = 2'($urandom_range(0, 3));
      s.exe_rs1      = REG_AW'($urandom_range(0, 7));
      s.exe_rs2      = REG_AW'($urandom_range(0, 7));
      s.exe_rd       = REG_AW'($urandom_range(0, 7));
      s.exe_we       = ($urandom_range(0, 3) != 0);
      s.exe_is_load  = ($urandom_range(0, 2) == 0);
      s.exe_redirect = ($urandom_range(0, 11) == 0);
      s.fwd_rd       = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
      s.fwd_we       = N_FWD'($urandom_range(0, 3));
      s.imem         = ($urandom_range(0, 7) == 0);
      s.dmem         = ($urandom_range(0, 6) == 0);
      apply(s);
    end
    apply(idle_s());
    // Bounded drain of the scoreboard
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
